pinwheel_bus_arbiter: RTL and testbench

- Shares one block_ram data port between two requesters: m0 is the pinwheel_core data bus, m1 is a loader/debug master (e.g. a serial-fed memory loader).
- Fixed priority to m0, with a starvation counter that forces m1 through after a bounded wait.
- Routes the 1-cycle-latency RAM response back to the master that issued the request.
- Sits between core/loader and the 0x8xxxxxxx data_ram instance.

---
 rtl/pinwheel_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_pinwheel_bus_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pinwheel_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pinwheel_bus_arbiter
// Purpose  : Two-master arbiter for the block_ram data port, with fixed
//            priority to the core and a starvation counter for the loader.
// Revision : 1.0 - initial release
// ============================================================================
module pinwheel_bus_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              m0_a_valid,
    input  logic [2:0]        m0_a_opcode,
    input  logic [ADDR_W-1:0] m0_a_address,
    input  logic [3:0]        m0_a_mask,
    input  logic [31:0]       m0_a_data,
    output logic              m0_a_ready,
    output logic              m0_d_valid,
    output logic [31:0]       m0_d_data,
    output logic              m0_d_error,

    input  logic              m1_a_valid,
    input  logic [2:0]        m1_a_opcode,
    input  logic [ADDR_W-1:0] m1_a_address,
    input  logic [3:0]        m1_a_mask,
    input  logic [31:0]       m1_a_data,
    output logic              m1_a_ready,
    output logic              m1_d_valid,
    output logic [31:0]       m1_d_data,
    output logic              m1_d_error,

    output logic              s_a_valid,
    output logic [2:0]        s_a_opcode,
    output logic [ADDR_W-1:0] s_a_address,
    output logic [3:0]        s_a_mask,
    output logic [31:0]       s_a_data,
    input  logic [31:0]       s_d_data,

    output logic              grant_m1
);

    localparam int                 c_CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);
    localparam logic [2:0]         c_OP_PUT_FULL = 3'd0;
    localparam logic [2:0]         c_OP_PUT_PART = 3'd1;
    localparam logic [2:0]         c_OP_GET      = 3'd4;

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_pend_valid;
    logic               r_pend_src;
    logic               r_pend_get;
    logic               r_pend_err;

    logic               w_req_any;
    logic               w_grant_m1;
    logic [2:0]         w_sel_opcode;
    logic               w_illegal;
    logic [31:0]        w_pend_data;

    // Request-side outputs are gated by reset_n so they drop the instant
    // reset asserts, not at the next edge.
    always_comb begin
        w_req_any    = reset_n & (m0_a_valid | m1_a_valid);
        w_grant_m1   = reset_n & m1_a_valid & (~m0_a_valid | (r_wait_cnt == c_STARVE_MAX));
        w_sel_opcode = w_grant_m1 ? m1_a_opcode : m0_a_opcode;
        w_illegal    = w_req_any & (w_sel_opcode != c_OP_PUT_FULL) &
                       (w_sel_opcode != c_OP_PUT_PART) & (w_sel_opcode != c_OP_GET);
    end

    always_comb begin
        m0_a_ready  = w_req_any & ~w_grant_m1;
        m1_a_ready  = w_grant_m1;
        grant_m1    = w_grant_m1;
        s_a_valid   = w_req_any & ~w_illegal;
        s_a_opcode  = '0;
        s_a_address = '0;
        s_a_mask    = '0;
        s_a_data    = '0;
        if (w_req_any) begin
            s_a_opcode  = w_sel_opcode;
            s_a_address = w_grant_m1 ? m1_a_address : m0_a_address;
            s_a_mask    = w_grant_m1 ? m1_a_mask    : m0_a_mask;
            s_a_data    = w_grant_m1 ? m1_a_data    : m0_a_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt   <= '0;
            r_pend_valid <= 1'b0;
            r_pend_src   <= 1'b0;
            r_pend_get   <= 1'b0;
            r_pend_err   <= 1'b0;
        end else begin
            if (m1_a_valid && !w_grant_m1) begin
                if (r_wait_cnt != c_STARVE_MAX) begin
                    r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                end
            end else begin
                r_wait_cnt <= '0;
            end
            r_pend_valid <= w_req_any;
            r_pend_src   <= w_grant_m1;
            r_pend_get   <= (w_sel_opcode == c_OP_GET);
            r_pend_err   <= w_illegal;
        end
    end

    // RAM read data is only forwarded for a good Get; Put acks and errors return 0.
    always_comb begin
        w_pend_data = (r_pend_get & ~r_pend_err) ? s_d_data : 32'd0;
        m0_d_valid  = r_pend_valid & ~r_pend_src;
        m1_d_valid  = r_pend_valid &  r_pend_src;
        m0_d_data   = m0_d_valid ? w_pend_data : 32'd0;
        m1_d_data   = m1_d_valid ? w_pend_data : 32'd0;
        m0_d_error  = m0_d_valid & r_pend_err;
        m1_d_error  = m1_d_valid & r_pend_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_pinwheel_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pinwheel_bus_arbiter
// Purpose  : Directed self-checking bench for pinwheel_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pinwheel_bus_arbiter;

    logic        clock;
    logic        reset_n;
    logic        m0_a_valid, m1_a_valid;
    logic [2:0]  m0_a_opcode, m1_a_opcode;
    logic [31:0] m0_a_address, m1_a_address;
    logic [3:0]  m0_a_mask, m1_a_mask;
    logic [31:0] m0_a_data, m1_a_data;
    logic        m0_a_ready, m1_a_ready;
    logic        m0_d_valid, m1_d_valid;
    logic [31:0] m0_d_data, m1_d_data;
    logic        m0_d_error, m1_d_error;
    logic        s_a_valid;
    logic [2:0]  s_a_opcode;
    logic [31:0] s_a_address;
    logic [3:0]  s_a_mask;
    logic [31:0] s_a_data;
    logic [31:0] s_d_data;
    logic        grant_m1;

    int n_total = 0;
    int n_bad   = 0;

    pinwheel_bus_arbiter #(.STARVE_MAX(4), .ADDR_W(32)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .m0_a_valid(m0_a_valid), .m0_a_opcode(m0_a_opcode), .m0_a_address(m0_a_address),
        .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data), .m0_a_ready(m0_a_ready),
        .m0_d_valid(m0_d_valid), .m0_d_data(m0_d_data), .m0_d_error(m0_d_error),
        .m1_a_valid(m1_a_valid), .m1_a_opcode(m1_a_opcode), .m1_a_address(m1_a_address),
        .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data), .m1_a_ready(m1_a_ready),
        .m1_d_valid(m1_d_valid), .m1_d_data(m1_d_data), .m1_d_error(m1_d_error),
        .s_a_valid(s_a_valid), .s_a_opcode(s_a_opcode), .s_a_address(s_a_address),
        .s_a_mask(s_a_mask), .s_a_data(s_a_data), .s_d_data(s_d_data),
        .grant_m1(grant_m1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_m0(input logic v, input logic [2:0] op, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] data);
        m0_a_valid = v; m0_a_opcode = op; m0_a_address = addr; m0_a_mask = mask; m0_a_data = data;
    endtask

    task automatic set_m1(input logic v, input logic [2:0] op, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] data);
        m1_a_valid = v; m1_a_opcode = op; m1_a_address = addr; m1_a_mask = mask; m1_a_data = data;
    endtask

    logic [31:0] rd_tbl [0:2];
    logic        prev_g;

    initial begin
        rd_tbl[0] = 32'h11; rd_tbl[1] = 32'h22; rd_tbl[2] = 32'h33;
        prev_g = 1'b0;
        reset_n = 1'b0;
        s_d_data = 32'h0;
        set_m0(1'b1, 3'd4, 32'h8000_0000, 4'hF, 32'h0);
        set_m1(1'b0, 3'd0, 32'h0, 4'h0, 32'h0);

        // Reset: combinational request outputs must be held low too
        @(posedge clock); @(posedge clock); #1;
        check("rst_m0_ready", {31'd0, m0_a_ready}, 32'd0);
        check("rst_s_valid",  {31'd0, s_a_valid},  32'd0);
        check("rst_m0_dvalid", {31'd0, m0_d_valid}, 32'd0);
        check("rst_m0_ddata", m0_d_data, 32'd0);
        check("rst_grant_m1", {31'd0, grant_m1}, 32'd0);

        // m0 Get
        @(negedge clock);
        reset_n = 1'b1;
        set_m0(1'b1, 3'd4, 32'h8000_0010, 4'hF, 32'h0);
        #1;
        check("get_m0_ready", {31'd0, m0_a_ready}, 32'd1);
        check("get_s_valid",  {31'd0, s_a_valid},  32'd1);
        check("get_s_addr",   s_a_address, 32'h8000_0010);
        check("get_s_op",     {29'd0, s_a_opcode}, 32'd4);
        @(negedge clock);
        set_m0(1'b0, 3'd0, 32'h0, 4'h0, 32'h0);
        s_d_data = 32'hDEAD_BEEF;
        #1;
        check("get_m0_dvalid", {31'd0, m0_d_valid}, 32'd1);
        check("get_m0_ddata",  m0_d_data, 32'hDEAD_BEEF);
        check("get_m1_dvalid", {31'd0, m1_d_valid}, 32'd0);
        check("idle_s_valid",  {31'd0, s_a_valid},  32'd0);

        // m1 PutPartialData with m0 idle
        @(negedge clock);
        set_m1(1'b1, 3'd1, 32'h8000_0004, 4'b0011, 32'h0000_1234);
        #1;
        check("pp_grant_m1", {31'd0, grant_m1}, 32'd1);
        check("pp_m1_ready", {31'd0, m1_a_ready}, 32'd1);
        check("pp_m0_ready", {31'd0, m0_a_ready}, 32'd0);
        check("pp_s_op",     {29'd0, s_a_opcode}, 32'd1);
        check("pp_s_mask",   {28'd0, s_a_mask}, 32'd3);
        check("pp_s_data",   s_a_data, 32'h0000_1234);
        @(negedge clock);
        set_m1(1'b0, 3'd0, 32'h0, 4'h0, 32'h0);
        s_d_data = 32'hFFFF_FFFF;
        #1;
        check("pp_m1_dvalid", {31'd0, m1_d_valid}, 32'd1);
        check("pp_m1_ddata",  m1_d_data, 32'd0);
        check("pp_m0_dvalid", {31'd0, m0_d_valid}, 32'd0);

        // Both masters continuously valid: m1 wins every fifth cycle
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            set_m0(1'b1, 3'd4, 32'h8000_0020, 4'hF, 32'h0);
            set_m1(1'b1, 3'd4, 32'h8000_0040, 4'hF, 32'h0);
            #1;
            check("starve_grant", {31'd0, grant_m1}, {31'd0, (i % 5 == 4)});
            check("starve_m0_ready", {31'd0, m0_a_ready}, {31'd0, (i % 5 != 4)});
            check("starve_s_addr", s_a_address, (i % 5 == 4) ? 32'h8000_0040 : 32'h8000_0020);
            if (i > 0) check("starve_m1_dvalid", {31'd0, m1_d_valid}, {31'd0, prev_g});
            prev_g = (i % 5 == 4);
        end
        @(negedge clock);
        set_m0(1'b0, 3'd0, 32'h0, 4'h0, 32'h0);
        set_m1(1'b0, 3'd0, 32'h0, 4'h0, 32'h0);

        // Three back-to-back m0 Gets
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (k < 3) set_m0(1'b1, 3'd4, 32'h8000_0100 + 32'(4 * k), 4'hF, 32'h0);
            else       set_m0(1'b0, 3'd0, 32'h0, 4'h0, 32'h0);
            s_d_data = (k > 0) ? rd_tbl[k-1] : 32'h0;
            #1;
            if (k < 3) check("b2b_m0_ready", {31'd0, m0_a_ready}, 32'd1);
            if (k > 0) begin
                check("b2b_m0_dvalid", {31'd0, m0_d_valid}, 32'd1);
                check("b2b_m0_ddata", m0_d_data, rd_tbl[k-1]);
            end
        end

        // Illegal opcode from m1
        @(negedge clock);
        set_m1(1'b1, 3'd3, 32'h8000_0200, 4'hF, 32'h0);
        #1;
        check("ill_m1_ready", {31'd0, m1_a_ready}, 32'd1);
        check("ill_s_valid",  {31'd0, s_a_valid},  32'd0);
        @(negedge clock);
        set_m1(1'b0, 3'd0, 32'h0, 4'h0, 32'h0);
        s_d_data = 32'hA5A5_A5A5;
        #1;
        check("ill_m1_dvalid", {31'd0, m1_d_valid}, 32'd1);
        check("ill_m1_derr",   {31'd0, m1_d_error}, 32'd1);
        check("ill_m1_ddata",  m1_d_data, 32'd0);

        // Asynchronous reset with a response outstanding
        @(negedge clock);
        set_m0(1'b1, 3'd4, 32'h8000_0300, 4'hF, 32'h0);
        s_d_data = 32'h5555_5555;
        @(posedge clock); #2;
        check("ar_m0_dvalid_pre", {31'd0, m0_d_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("ar_m0_dvalid", {31'd0, m0_d_valid}, 32'd0);
        check("ar_m0_ddata",  m0_d_data, 32'd0);
        check("ar_m0_ready",  {31'd0, m0_a_ready}, 32'd0);
        check("ar_s_valid",   {31'd0, s_a_valid}, 32'd0);
        @(negedge clock);
        set_m0(1'b0, 3'd0, 32'h0, 4'h0, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clock); #1;
            check("ar_post_dvalid", {31'd0, m0_d_valid}, 32'd0);
        end

        // wait_cnt restarts at 0 after reset: m0 wins the first four conflicts
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            set_m0(1'b1, 3'd0, 32'h8000_0400, 4'hF, 32'h1);
            set_m1(1'b1, 3'd0, 32'h8000_0500, 4'hF, 32'h2);
            #1;
            check("post_rst_grant", {31'd0, grant_m1}, {31'd0, (i == 4)});
        end
        @(negedge clock);
        set_m0(1'b0, 3'd0, 32'h0, 4'h0, 32'h0);
        set_m1(1'b0, 3'd0, 32'h0, 4'h0, 32'h0);
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
